// File: rtl/buffer_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : buffer_read_scheduler
// Description : Shares one read buffer among NUM_PU processing units.
//               Memory-controller read requests {size, pu_id} are queued in
//               a small FIFO. Buffer-type requests are serviced one at a
//               time: exactly `size` words are popped from the read buffer,
//               each pop is steered to the owning PU, and the final pop is
//               flagged with buffer_read_last.
// Ports       : clk, reset (async, active-low)
//               rd_req / rd_req_size / rd_req_pu_id / rd_req_d_type : request in
//               rd_req_ready      : request FIFO not full
//               buffer_read_empty : read buffer has no data
//               buffer_read_pop   : pop the read buffer this cycle
//               pu_read_req       : one-hot PU being serviced (READ only)
//               pu_read_ready     : per-PU word acceptance
//               pu_read_pop       : buffer_read_pop steered to the active PU
//               buffer_read_last  : final pop of a request
//               busy              : request in service or queued
//               err_overflow      : sticky, request arrived while FIFO full
//               err_bad_pu        : sticky, request carried pu_id >= NUM_PU
// Revision    : 1.0 - initial release
// ============================================================================
module buffer_read_scheduler #(
    parameter int NUM_PU         = 1,
    parameter int D_TYPE_W       = 2,
    parameter int RD_SIZE_W      = 20,
    parameter int BUF_D_TYPE     = 1,
    parameter int REQ_FIFO_DEPTH = 4,
    localparam int PU_ID_W       = $clog2(NUM_PU) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd_req,
    input  logic [RD_SIZE_W-1:0] rd_req_size,
    input  logic [PU_ID_W-1:0]   rd_req_pu_id,
    input  logic [D_TYPE_W-1:0]  rd_req_d_type,
    output logic                 rd_req_ready,
    input  logic                 buffer_read_empty,
    output logic                 buffer_read_pop,
    output logic [NUM_PU-1:0]    pu_read_req,
    input  logic [NUM_PU-1:0]    pu_read_ready,
    output logic [NUM_PU-1:0]    pu_read_pop,
    output logic                 buffer_read_last,
    output logic                 busy,
    output logic                 err_overflow,
    output logic                 err_bad_pu
);

    localparam int AW = $clog2(REQ_FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0]        C_DEPTH      = CW'(REQ_FIFO_DEPTH);
    localparam logic [D_TYPE_W-1:0]  C_BUF_D_TYPE = D_TYPE_W'(BUF_D_TYPE);
    localparam logic [PU_ID_W-1:0]   C_NUM_PU     = PU_ID_W'(NUM_PU);
    localparam logic [RD_SIZE_W-1:0] C_ONE        = RD_SIZE_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_READ = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [RD_SIZE_W-1:0] r_fifo_size [REQ_FIFO_DEPTH];
    logic [PU_ID_W-1:0]   r_fifo_pu   [REQ_FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 r_alive;      // holds ready low until the first edge after reset
    logic                 r_err_overflow;

    state_t               r_state;
    logic [PU_ID_W-1:0]   r_pu_id;
    logic [RD_SIZE_W-1:0] r_remaining;
    logic                 r_err_bad_pu;

    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_push;
    logic                 w_deq;
    logic                 w_rd_pop;
    logic [NUM_PU-1:0]    w_pu_sel;

    assign w_fifo_full  = (r_count == C_DEPTH);
    assign w_fifo_empty = (r_count == '0);

    // Ready comes from registered fullness only, so a push that coincides
    // with a dequeue on a full FIFO is still rejected as an overflow.
    assign rd_req_ready = r_alive & ~w_fifo_full;
    assign w_push       = rd_req & rd_req_ready & (rd_req_d_type == C_BUF_D_TYPE);
    assign w_deq        = (r_state == S_IDLE) & ~w_fifo_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_alive        <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_deq) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_deq) begin
                r_count <= r_count - 1'b1;
            end
            if (rd_req && w_fifo_full) begin
                r_err_overflow <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_size[r_wr_ptr] <= rd_req_size;
            r_fifo_pu[r_wr_ptr]   <= rd_req_pu_id;
        end
    end

    // ------------------------------------------------------------------
    // Service FSM
    // ------------------------------------------------------------------
    // The head entry is captured on the dequeue edge, so LOAD only has to
    // classify it (empty or bad-PU requests return straight to IDLE).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_pu_id      <= '0;
            r_remaining  <= '0;
            r_err_bad_pu <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_pu_id     <= r_fifo_pu[r_rd_ptr];
                        r_remaining <= r_fifo_size[r_rd_ptr];
                        r_state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (r_pu_id >= C_NUM_PU) begin
                        r_err_bad_pu <= 1'b1;
                        r_state      <= S_IDLE;
                    end else if (r_remaining == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    if (w_rd_pop) begin
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == C_ONE) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // PU steering
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_PU; i++) begin : g_pu_sel
            assign w_pu_sel[i] = (r_pu_id == PU_ID_W'(i));
        end
    endgenerate

    // Selecting the ready bit through the one-hot mask avoids indexing
    // pu_read_ready with a pu_id that may be wider than NUM_PU.
    assign w_rd_pop = (r_state == S_READ) & ~buffer_read_empty
                    & (|(pu_read_ready & w_pu_sel));

    assign buffer_read_pop  = w_rd_pop;
    assign buffer_read_last = w_rd_pop & (r_remaining == C_ONE);
    assign pu_read_req      = (r_state == S_READ) ? w_pu_sel : '0;
    assign pu_read_pop      = w_rd_pop ? w_pu_sel : '0;
    assign busy             = (r_state != S_IDLE) | ~w_fifo_empty;
    assign err_overflow     = r_err_overflow;
    assign err_bad_pu       = r_err_bad_pu;

endmodule
`default_nettype wire

// File: tb/tb_buffer_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_buffer_read_scheduler
// Description : Self-checking bench for buffer_read_scheduler (NUM_PU=4,
//               RD_SIZE_W=8). Expected pop streams come from a request-level
//               model: each accepted buffer request with size>0 and a valid
//               PU yields `size` pops to that PU, last flagged on the final.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buffer_read_scheduler;

    localparam int NUM_PU     = 4;
    localparam int D_TYPE_W   = 2;
    localparam int RD_SIZE_W  = 8;
    localparam int BUF_D_TYPE = 1;
    localparam int DEPTH      = 4;
    localparam int PU_ID_W    = $clog2(NUM_PU) + 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 rd_req;
    logic [RD_SIZE_W-1:0] rd_req_size;
    logic [PU_ID_W-1:0]   rd_req_pu_id;
    logic [D_TYPE_W-1:0]  rd_req_d_type;
    logic                 rd_req_ready;
    logic                 buffer_read_empty;
    logic                 buffer_read_pop;
    logic [NUM_PU-1:0]    pu_read_req;
    logic [NUM_PU-1:0]    pu_read_ready;
    logic [NUM_PU-1:0]    pu_read_pop;
    logic                 buffer_read_last;
    logic                 busy;
    logic                 err_overflow;
    logic                 err_bad_pu;

    buffer_read_scheduler #(
        .NUM_PU         (NUM_PU),
        .D_TYPE_W       (D_TYPE_W),
        .RD_SIZE_W      (RD_SIZE_W),
        .BUF_D_TYPE     (BUF_D_TYPE),
        .REQ_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .rd_req            (rd_req),
        .rd_req_size       (rd_req_size),
        .rd_req_pu_id      (rd_req_pu_id),
        .rd_req_d_type     (rd_req_d_type),
        .rd_req_ready      (rd_req_ready),
        .buffer_read_empty (buffer_read_empty),
        .buffer_read_pop   (buffer_read_pop),
        .pu_read_req       (pu_read_req),
        .pu_read_ready     (pu_read_ready),
        .pu_read_pop       (pu_read_pop),
        .buffer_read_last  (buffer_read_last),
        .busy              (busy),
        .err_overflow      (err_overflow),
        .err_bad_pu        (err_bad_pu)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Pop monitor (samples on the falling edge)
    // ------------------------------------------------------------------
    int log_pu[$];
    bit log_last[$];
    int log_cyc[$];
    int viol;
    int mon_idx;

    always @(negedge clk) begin
        if (reset) begin
            if (buffer_read_pop) begin
                mon_idx = -1;
                for (int i = 0; i < NUM_PU; i++) if (pu_read_pop[i]) mon_idx = i;
                log_pu.push_back(mon_idx);
                log_last.push_back(buffer_read_last);
                log_cyc.push_back(cyc);
                if (buffer_read_empty || ((pu_read_ready & pu_read_req) == '0)) viol++;
                if (pu_read_pop !== pu_read_req) viol++;
                if ($countones(pu_read_req) != 1) viol++;
            end else begin
                if (pu_read_pop !== '0 || buffer_read_last !== 1'b0) viol++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: expected pop stream
    // ------------------------------------------------------------------
    int exp_pu[$];
    bit exp_last[$];

    task automatic model_add(input int dt, input int size, input int pu);
        if (dt == BUF_D_TYPE && size != 0 && pu < NUM_PU) begin
            for (int k = 0; k < size; k++) begin
                exp_pu.push_back(pu);
                exp_last.push_back(k == size - 1);
            end
        end
    endtask

    function automatic int seq_mismatch();
        int m = 0;
        if (log_pu.size() != exp_pu.size()) m++;
        for (int i = 0; i < log_pu.size() && i < exp_pu.size(); i++)
            if (log_pu[i] != exp_pu[i] || log_last[i] != exp_last[i]) m++;
        return m;
    endfunction

    task automatic clear_logs();
        log_pu.delete(); log_last.delete(); log_cyc.delete();
        exp_pu.delete(); exp_last.delete();
        viol = 0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers (called at #1 after a rising edge, return there)
    // ------------------------------------------------------------------
    task automatic send(input int size, input int pu, input int dt, output int edge_no);
        rd_req        = 1'b1;
        rd_req_size   = RD_SIZE_W'(size);
        rd_req_pu_id  = PU_ID_W'(pu);
        rd_req_d_type = D_TYPE_W'(dt);
        @(posedge clk); #1;
        edge_no = cyc;
        rd_req  = 1'b0;
    endtask

    task automatic randomize_stalls();
        buffer_read_empty = ($urandom_range(0, 3) == 0);
        pu_read_ready     = NUM_PU'($urandom);
    endtask

    task automatic drain(input int maxc, input bit rnd, output bit timed_out);
        int n = 0;
        while (busy === 1'b1 && n < maxc) begin
            if (rnd) randomize_stalls();
            else begin buffer_read_empty = 1'b0; pu_read_ready = '1; end
            @(posedge clk); #1;
            n++;
        end
        timed_out = (busy !== 1'b0);
        buffer_read_empty = 1'b0;
        pu_read_ready     = '1;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({rd_req_ready, buffer_read_pop, pu_read_req, pu_read_pop, buffer_read_last,
             busy, err_overflow, err_bad_pu} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got ready=%b pop=%b req=%b pupop=%b last=%b busy=%b ovf=%b bad=%b want all 0",
                     rd_req_ready, buffer_read_pop, pu_read_req, pu_read_pop, buffer_read_last,
                     busy, err_overflow, err_bad_pu);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if (rd_req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got ready=%b busy=%b want ready=1 busy=0", rd_req_ready, busy);
        end
    endtask

    task automatic test_single();
        int e; bit b6, b7;
        clear_logs();
        send(5, 0, 1, e);
        model_add(1, 5, 0);
        repeat (10) begin
            @(posedge clk); #1;
            if (cyc == e + 6) b6 = busy;
            if (cyc == e + 7) b7 = busy;
        end
        total++;
        if (seq_mismatch() != 0) begin
            bad++; $display("FAIL single_seq got %0d pops want %0d", log_pu.size(), exp_pu.size());
        end
        total++;
        if ((log_cyc.size() > 0 ? log_cyc[0] - e : -1) !== 2) begin
            bad++; $display("FAIL single_latency got %0d want 2", log_cyc.size() > 0 ? log_cyc[0] - e : -1);
        end
        total++;
        if ((log_cyc.size() == 5 ? log_cyc[4] - log_cyc[0] : -1) !== 4) begin
            bad++; $display("FAIL single_consecutive got span %0d want 4", log_cyc.size() == 5 ? log_cyc[4] - log_cyc[0] : -1);
        end
        total++;
        if (b6 !== 1'b1 || b7 !== 1'b0) begin
            bad++; $display("FAIL single_busy got last_cycle=%b after=%b want 1 0", b6, b7);
        end
    endtask

    task automatic test_random_stalls();
        int e; bit to;
        clear_logs();
        send(100, 2, 1, e);
        model_add(1, 100, 2);
        drain(3000, 1'b1, to);
        total++;
        if (to) begin bad++; $display("FAIL stalls_timeout busy=%b want 0", busy); end
        total++;
        if (seq_mismatch() != 0) begin
            bad++; $display("FAIL stalls_seq got %0d pops want %0d", log_pu.size(), exp_pu.size());
        end
        total++;
        if (viol !== 0) begin bad++; $display("FAIL stalls_protocol got %0d violations want 0", viol); end
    endtask

    task automatic test_random_mix();
        int e, dt, sz, pu, w; bit to;
        clear_logs();
        for (int r = 0; r < 8; r++) begin
            dt = $urandom_range(0, 3);
            sz = $urandom_range(0, 12);
            pu = $urandom_range(0, 7);
            w  = 0;
            repeat ($urandom_range(0, 3)) begin randomize_stalls(); @(posedge clk); #1; end
            while (rd_req_ready !== 1'b1 && w < 400) begin
                randomize_stalls(); @(posedge clk); #1; w++;
            end
            send(sz, pu, dt, e);
            model_add(dt, sz, pu);
        end
        drain(3000, 1'b1, to);
        total++;
        if (to) begin bad++; $display("FAIL mix_timeout busy=%b want 0", busy); end
        total++;
        if (seq_mismatch() != 0) begin
            bad++; $display("FAIL mix_seq got %0d pops want %0d", log_pu.size(), exp_pu.size());
        end
        total++;
        if (viol !== 0) begin bad++; $display("FAIL mix_protocol got %0d violations want 0", viol); end
    endtask

    task automatic test_back_to_back();
        int e1, e2; bit to;
        clear_logs();
        send(4, 1, 1, e1);
        send(3, 3, 1, e2);
        model_add(1, 4, 1);
        model_add(1, 3, 3);
        drain(200, 1'b0, to);
        total++;
        if (to || seq_mismatch() != 0) begin
            bad++; $display("FAIL b2b_seq got %0d pops want %0d", log_pu.size(), exp_pu.size());
        end
        total++;
        if ((log_cyc.size() == 7 ? log_cyc[4] - log_cyc[3] : -1) !== 3) begin
            bad++; $display("FAIL b2b_gap got %0d want 3", log_cyc.size() == 7 ? log_cyc[4] - log_cyc[3] : -1);
        end
    endtask

    task automatic test_filter_zero();
        int e; bit to;
        clear_logs();
        send(7, 0, 0, e); model_add(0, 7, 0);
        send(0, 1, 1, e); model_add(1, 0, 1);
        send(3, 1, 1, e); model_add(1, 3, 1);
        drain(200, 1'b0, to);
        total++;
        if (to || seq_mismatch() != 0) begin
            bad++; $display("FAIL filter_seq got %0d pops want %0d", log_pu.size(), exp_pu.size());
        end
    endtask

    task automatic test_max_size();
        int e; bit to;
        clear_logs();
        send(255, 3, 1, e);
        model_add(1, 255, 3);
        drain(600, 1'b0, to);
        total++;
        if (to || seq_mismatch() != 0) begin
            bad++; $display("FAIL max_size_seq got %0d pops want %0d", log_pu.size(), exp_pu.size());
        end
    endtask

    task automatic test_bad_pu();
        int e; bit to;
        clear_logs();
        total++;
        if (err_bad_pu !== 1'b0) begin bad++; $display("FAIL bad_pu_pre got %b want 0", err_bad_pu); end
        send(4, 5, 1, e); model_add(1, 4, 5);
        send(2, 3, 1, e); model_add(1, 2, 3);
        drain(200, 1'b0, to);
        total++;
        if (to || seq_mismatch() != 0) begin
            bad++; $display("FAIL bad_pu_seq got %0d pops want %0d", log_pu.size(), exp_pu.size());
        end
        total++;
        if (err_bad_pu !== 1'b1) begin bad++; $display("FAIL bad_pu_flag got %b want 1", err_bad_pu); end
    endtask

    task automatic test_overflow();
        int e; bit to; bit rdy[5];
        clear_logs();
        total++;
        if (err_overflow !== 1'b0) begin bad++; $display("FAIL overflow_pre got %b want 0", err_overflow); end
        buffer_read_empty = 1'b1;
        send(2, 1, 1, e);
        model_add(1, 2, 1);
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            rdy[k]        = rd_req_ready;
            rd_req        = 1'b1;
            rd_req_size   = RD_SIZE_W'(k + 1);
            rd_req_pu_id  = PU_ID_W'(k % NUM_PU);
            rd_req_d_type = D_TYPE_W'(BUF_D_TYPE);
            if (k < DEPTH) model_add(1, k + 1, k % NUM_PU);
            @(posedge clk); #1;
        end
        rd_req = 1'b0;
        total++;
        if ({rdy[0], rdy[1], rdy[2], rdy[3], rdy[4]} !== 5'b11110) begin
            bad++; $display("FAIL overflow_ready got %b want 11110", {rdy[0], rdy[1], rdy[2], rdy[3], rdy[4]});
        end
        total++;
        if (err_overflow !== 1'b1 || log_pu.size() !== 0) begin
            bad++; $display("FAIL overflow_flag got err=%b pops=%0d want err=1 pops=0", err_overflow, log_pu.size());
        end
        drain(300, 1'b0, to);
        total++;
        if (to || seq_mismatch() != 0) begin
            bad++; $display("FAIL overflow_seq got %0d pops want %0d", log_pu.size(), exp_pu.size());
        end
    endtask

    task automatic test_reset_mid_read();
        int e, w; bit to;
        clear_logs();
        send(10, 2, 1, e);
        w = 0;
        while (log_pu.size() < 3 && w < 50) begin @(posedge clk); #1; w++; end
        for (int k = 0; k < 3; k++) begin exp_pu.push_back(2); exp_last.push_back(1'b0); end
        reset = 1'b0;
        #1;
        total++;
        if ({rd_req_ready, buffer_read_pop, pu_read_req, pu_read_pop, buffer_read_last,
             busy, err_overflow, err_bad_pu} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs got pop=%b req=%b pupop=%b last=%b busy=%b ovf=%b bad=%b want all 0",
                     buffer_read_pop, pu_read_req, pu_read_pop, buffer_read_last, busy, err_overflow, err_bad_pu);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (log_pu.size() !== 3 || busy !== 1'b0 || rd_req_ready !== 1'b1) begin
            bad++; $display("FAIL midreset_quiet got pops=%0d busy=%b ready=%b want 3 0 1",
                            log_pu.size(), busy, rd_req_ready);
        end
        send(2, 0, 1, e);
        model_add(1, 2, 0);
        drain(200, 1'b0, to);
        total++;
        if (to || seq_mismatch() != 0) begin
            bad++; $display("FAIL midreset_seq got %0d pops want %0d", log_pu.size(), exp_pu.size());
        end
    endtask

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    initial begin
        rd_req            = 1'b0;
        rd_req_size       = '0;
        rd_req_pu_id      = '0;
        rd_req_d_type     = '0;
        buffer_read_empty = 1'b0;
        pu_read_ready     = '1;
        viol              = 0;
        test_reset();
        test_single();
        test_random_stalls();
        test_back_to_back();
        test_filter_zero();
        test_max_size();
        test_random_mix();
        test_bad_pu();
        test_overflow();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
